pic_core_stack: RTL and testbench

//  Parametrised successor to the team's 14-bit PIC-style multicycle core. Fetches

---
 rtl/pic_core_stack.sv | 271 +++++++++++++++++++++++++++
 tb/tb_pic_core_stack.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_core_stack.sv
// pic_core_stack: 5-cycle PIC mid-range style core with a hardware return stack,
// Z/C status, sticky stack-error flags and an instruction-retire strobe.
module pic_core_stack #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PC_W        = 11,
    parameter int unsigned RAM_AW      = 7,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PC_W-1:0]   rom_addr,
    input  logic [13:0]       rom_data,
    output logic [DATA_W-1:0] w_q,
    output logic [1:0]        status_q,
    output logic [PC_W-1:0]   pc_q,
    output logic              instr_done,
    output logic              stk_ovf,
    output logic              stk_unf
);
    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
    localparam int unsigned SP_W      = $clog2(STACK_DEPTH);
    localparam int unsigned CNT_W     = SP_W + 1;
    localparam logic [RAM_AW-1:0] STATUS_ADDR = RAM_AW'(3);

    typedef enum logic [2:0] {S_CLR, S_MAR, S_INC, S_IR, S_EXEC} state_t;

    state_t            state_q, state_d;
    logic [13:0]       ir_q, ir_d;
    logic [PC_W-1:0]   mar_q, mar_d, pc_d;
    logic [DATA_W-1:0] w_d;
    logic [1:0]        status_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, done_q, done_d;

    logic [DATA_W-1:0] ram_mem [RAM_DEPTH];
    logic [PC_W-1:0]   stk_mem [STACK_DEPTH];

    logic [RAM_AW-1:0] f_addr;
    logic [DATA_W-1:0] f_val, lit, bit_mask, status_view;
    logic              ram_we, push, pop, skip, wb;
    logic [DATA_W-1:0] ram_wdata, res;
    logic [DATA_W:0]   ext;

    // Operand fetch: file register (STATUS aliased at address 3), literal, bit mask
    always_comb begin
        f_addr         = ir_q[RAM_AW-1:0];
        status_view    = '0;
        status_view[2] = status_q[1];
        status_view[0] = status_q[0];
        f_val          = (f_addr == STATUS_ADDR) ? status_view : ram_mem[f_addr];
        lit            = DATA_W'(ir_q[7:0]);
        bit_mask       = DATA_W'(1) << ir_q[9:7];
    end

    // Next-state, decode and execute; all architectural updates land at end of S_EXEC
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        mar_d     = mar_q;
        pc_d      = pc_q;
        w_d       = w_q;
        status_d  = status_q;
        sp_d      = sp_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        done_d    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        push      = 1'b0;
        pop       = 1'b0;
        skip      = 1'b0;
        wb        = 1'b0;
        ext       = '0;
        res       = '0;
        case (state_q)
            S_CLR: begin
                ir_d    = '0;
                state_d = S_MAR;
            end
            S_MAR: begin
                mar_d   = pc_q;
                state_d = S_INC;
            end
            S_INC: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = S_IR;
            end
            S_IR: begin
                ir_d    = rom_data;
                done_d  = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_MAR;
                casez (ir_q)
                    14'b00_0000_0000_1000: pop = 1'b1;                          // RETURN
                    14'b00_0000_1???_????: begin ram_we = 1'b1; ram_wdata = w_q; end // MOVWF
                    14'b00_0001_0???_????: begin w_d = '0; status_d[1] = 1'b1; end   // CLRW
                    14'b00_0001_1???_????: begin                                 // CLRF
                        ram_we      = 1'b1;
                        ram_wdata   = '0;
                        status_d[1] = 1'b1;
                    end
                    14'b00_0010_????_????: begin                                 // SUBWF
                        ext      = {1'b0, f_val} - {1'b0, w_q};
                        res      = ext[DATA_W-1:0];
                        status_d = {~|res, ~ext[DATA_W]};
                        wb       = 1'b1;
                    end
                    14'b00_0011_????_????: begin                                 // DECF
                        res = f_val - DATA_W'(1); status_d[1] = ~|res; wb = 1'b1;
                    end
                    14'b00_0100_????_????: begin                                 // IORWF
                        res = f_val | w_q; status_d[1] = ~|res; wb = 1'b1;
                    end
                    14'b00_0101_????_????: begin                                 // ANDWF
                        res = f_val & w_q; status_d[1] = ~|res; wb = 1'b1;
                    end
                    14'b00_0110_????_????: begin                                 // XORWF
                        res = f_val ^ w_q; status_d[1] = ~|res; wb = 1'b1;
                    end
                    14'b00_0111_????_????: begin                                 // ADDWF
                        ext      = {1'b0, f_val} + {1'b0, w_q};
                        res      = ext[DATA_W-1:0];
                        status_d = {~|res, ext[DATA_W]};
                        wb       = 1'b1;
                    end
                    14'b00_1000_????_????: begin                                 // MOVF
                        res = f_val; status_d[1] = ~|res; wb = 1'b1;
                    end
                    14'b00_1001_????_????: begin                                 // COMF
                        res = ~f_val; status_d[1] = ~|res; wb = 1'b1;
                    end
                    14'b00_1010_????_????: begin                                 // INCF
                        res = f_val + DATA_W'(1); status_d[1] = ~|res; wb = 1'b1;
                    end
                    14'b00_1011_????_????: begin                                 // DECFSZ
                        res = f_val - DATA_W'(1); wb = 1'b1; skip = ~|res;
                    end
                    14'b00_1111_????_????: begin                                 // INCFSZ
                        res = f_val + DATA_W'(1); wb = 1'b1; skip = ~|res;
                    end
                    14'b01_00??_????_????: begin                                 // BCF
                        ram_we = 1'b1; ram_wdata = f_val & ~bit_mask;
                    end
                    14'b01_01??_????_????: begin                                 // BSF
                        ram_we = 1'b1; ram_wdata = f_val | bit_mask;
                    end
                    14'b01_10??_????_????: skip = ~|(f_val & bit_mask);          // BTFSC
                    14'b01_11??_????_????: skip = |(f_val & bit_mask);           // BTFSS
                    14'b10_0???_????_????: begin                                 // CALL
                        push = 1'b1; pc_d = ir_q[PC_W-1:0];
                    end
                    14'b10_1???_????_????: pc_d = ir_q[PC_W-1:0];                // GOTO
                    14'b11_00??_????_????: w_d = lit;                            // MOVLW
                    14'b11_01??_????_????: begin w_d = lit; pop = 1'b1; end      // RETLW
                    14'b11_1000_????_????: begin                                 // IORLW
                        res = lit | w_q; w_d = res; status_d[1] = ~|res;
                    end
                    14'b11_1001_????_????: begin                                 // ANDLW
                        res = lit & w_q; w_d = res; status_d[1] = ~|res;
                    end
                    14'b11_1010_????_????: begin                                 // XORLW
                        res = lit ^ w_q; w_d = res; status_d[1] = ~|res;
                    end
                    14'b11_110?_????_????: begin                                 // SUBLW
                        ext      = {1'b0, lit} - {1'b0, w_q};
                        res      = ext[DATA_W-1:0];
                        w_d      = res;
                        status_d = {~|res, ~ext[DATA_W]};
                    end
                    14'b11_111?_????_????: begin                                 // ADDLW
                        ext      = {1'b0, lit} + {1'b0, w_q};
                        res      = ext[DATA_W-1:0];
                        w_d      = res;
                        status_d = {~|res, ext[DATA_W]};
                    end
                    default: ;
                endcase

                if (wb) begin
                    if (ir_q[7]) begin
                        ram_we    = 1'b1;
                        ram_wdata = res;
                    end else begin
                        w_d = res;
                    end
                end
                // A write that lands on STATUS wins over the op's own flag update
                if (ram_we && (f_addr == STATUS_ADDR)) begin
                    status_d = {ram_wdata[2], ram_wdata[0]};
                end
                if (skip) begin
                    pc_d = pc_q + PC_W'(1);
                end
                // Push on full overwrites the oldest entry; count saturates
                if (push) begin
                    sp_d = sp_q + SP_W'(1);
                    if (cnt_q == CNT_W'(STACK_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // Pop on empty restarts at address 0 and leaves the pointer alone
                if (pop) begin
                    if (cnt_q == '0) begin
                        pc_d  = '0;
                        unf_d = 1'b1;
                    end else begin
                        sp_d  = sp_q - SP_W'(1);
                        cnt_d = cnt_q - CNT_W'(1);
                        pc_d  = stk_mem[sp_q - SP_W'(1)];
                    end
                end
            end
            default: state_d = S_CLR;
        endcase
    end

    // State and architectural registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_CLR;
            ir_q     <= '0;
            mar_q    <= '0;
            pc_q     <= '0;
            w_q      <= '0;
            status_q <= '0;
            sp_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            mar_q    <= mar_d;
            pc_q     <= pc_d;
            w_q      <= w_d;
            status_q <= status_d;
            sp_q     <= sp_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            done_q   <= done_d;
        end
    end

    // Data RAM: contents survive reset; a write in the reset cycle is dropped
    always_ff @(posedge clk) begin
        if (reset && ram_we && (f_addr != STATUS_ADDR)) begin
            ram_mem[f_addr] <= ram_wdata;
        end
    end

    // Return-stack storage; CALL saves the already-incremented PC
    always_ff @(posedge clk) begin
        if (reset && push) begin
            stk_mem[sp_q] <= pc_q;
        end
    end

    assign rom_addr   = mar_q;
    assign instr_done = done_q;
    assign stk_ovf    = ovf_q;
    assign stk_unf    = unf_q;

endmodule

// File: tb/tb_pic_core_stack.sv
// tb_pic_core_stack: directed vector table plus hand-written corner sequences.
module tb_pic_core_stack;
    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] rom_addr8, rom_addr16, pc8, pc16;
    logic [13:0] rom_data8, rom_data16;
    logic [7:0]  w8;
    logic [15:0] w16;
    logic [1:0]  st8, st16;
    logic        done8, done16, ovf8, ovf16, unf8, unf16;

    logic [13:0] rom8  [2048];
    logic [13:0] rom16 [2048];

    int checks;
    int failures;
    int first;

    typedef struct packed {
        logic [10:0] addr;
        logic [13:0] instr;
        logic        retire;
        logic [7:0]  ew;
        logic [1:0]  est;
        logic [10:0] epc;
    } vec_t;
    vec_t vecs[$];

    assign rom_data8  = rom8[rom_addr8];
    assign rom_data16 = rom16[rom_addr16];

    always #5 clk = ~clk;

    pic_core_stack #(.DATA_W(8), .PC_W(11), .RAM_AW(7), .STACK_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr8), .rom_data(rom_data8),
        .w_q(w8), .status_q(st8), .pc_q(pc8), .instr_done(done8),
        .stk_ovf(ovf8), .stk_unf(unf8)
    );

    pic_core_stack #(.DATA_W(16), .PC_W(11), .RAM_AW(7), .STACK_DEPTH(8)) dut16 (
        .clk(clk), .reset(reset), .rom_addr(rom_addr16), .rom_data(rom_data16),
        .w_q(w16), .status_q(st16), .pc_q(pc16), .instr_done(done16),
        .stk_ovf(ovf16), .stk_unf(unf16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [10:0] a, input logic [13:0] i, input logic r,
                       input logic [7:0] ew, input logic [1:0] es, input logic [10:0] ep);
        vec_t v;
        v.addr = a; v.instr = i; v.retire = r; v.ew = ew; v.est = es; v.epc = ep;
        vecs.push_back(v);
    endtask

    task automatic clear_roms();
        for (int i = 0; i < 2048; i++) begin
            rom8[i]  = '0;
            rom16[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // Returns on the falling edge inside S_EXEC of the next instruction
    task automatic wait_exec(input bit wide, input string tag);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = wide ? done16 : done8;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: no instr_done within 20 cycles", tag);
        end
    endtask

    // Returns one falling edge after S_EXEC, once its writes have landed
    task automatic wait_retire(input bit wide, input string tag);
        wait_exec(wide, tag);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        clear_roms();

        // Reset in the middle of S_EXEC of a RAM write
        rom8[0] = 14'h30A5;   // MOVLW 0xA5
        rom8[1] = 14'h0085;   // MOVWF 0x05
        rom8[2] = 14'h3055;   // MOVLW 0x55
        rom8[3] = 14'h0085;   // MOVWF 0x05 (aborted)
        do_reset();
        repeat (3) wait_retire(1'b0, "t1 pre");
        chk("t1 w before abort", 32'(w8), 32'h55);
        wait_exec(1'b0, "t1 exec");
        reset   = 1'b0;
        rom8[0] = 14'h0805;   // MOVF 0x05,0
        repeat (2) @(negedge clk);
        chk("t1 reset w_q", 32'(w8), 32'h0);
        chk("t1 reset pc_q", 32'(pc8), 32'h0);
        chk("t1 reset status_q", 32'(st8), 32'h0);
        chk("t1 reset rom_addr", 32'(rom_addr8), 32'h0);
        chk("t1 reset instr_done", 32'(done8), 32'h0);
        chk("t1 reset stk flags", 32'({ovf8, unf8}), 32'h0);
        reset = 1'b1;
        first = 0;
        for (int k = 1; k <= 8 && first == 0; k++) begin
            @(negedge clk);
            if (done8) first = k;
        end
        // S_CLR, S_MAR, S_INC, S_IR, then S_EXEC is the fifth cycle
        chk("t1 instr_done rising edges after release", 32'(first), 32'd4);
        @(negedge clk);
        chk("t1 instr_done one cycle", 32'(done8), 32'h0);
        chk("t1 RAM[5] preserved", 32'(w8), 32'hA5);

        // Main instruction vectors: {addr, instr, retires, W, {Z,C}, PC after}
        add(11'h00, 14'h30FF, 1, 8'hFF, 2'b00, 11'h01);  // MOVLW FF
        add(11'h01, 14'h3E01, 1, 8'h00, 2'b11, 11'h02);  // ADDLW 01
        add(11'h02, 14'h3C00, 1, 8'h00, 2'b11, 11'h03);  // SUBLW 00
        add(11'h03, 14'h3005, 1, 8'h05, 2'b11, 11'h04);  // MOVLW 05
        add(11'h04, 14'h3C03, 1, 8'hFE, 2'b00, 11'h05);  // SUBLW 03 (borrow)
        add(11'h05, 14'h00A1, 1, 8'hFE, 2'b00, 11'h06);  // MOVWF 21
        add(11'h06, 14'h300F, 1, 8'h0F, 2'b00, 11'h07);  // MOVLW 0F
        add(11'h07, 14'h0521, 1, 8'h0E, 2'b00, 11'h08);  // ANDWF 21,0
        add(11'h08, 14'h38F0, 1, 8'hFE, 2'b00, 11'h09);  // IORLW F0
        add(11'h09, 14'h3AFE, 1, 8'h00, 2'b10, 11'h0A);  // XORLW FE
        add(11'h0A, 14'h09A1, 1, 8'h00, 2'b00, 11'h0B);  // COMF 21,1 -> 01
        add(11'h0B, 14'h0A21, 1, 8'h02, 2'b00, 11'h0C);  // INCF 21,0
        add(11'h0C, 14'h03A1, 1, 8'h02, 2'b10, 11'h0D);  // DECF 21,1 -> 00
        add(11'h0D, 14'h0821, 1, 8'h00, 2'b10, 11'h0E);  // MOVF 21,0
        add(11'h0E, 14'h3080, 1, 8'h80, 2'b10, 11'h0F);  // MOVLW 80
        add(11'h0F, 14'h00A2, 1, 8'h80, 2'b10, 11'h10);  // MOVWF 22
        add(11'h10, 14'h0722, 1, 8'h00, 2'b11, 11'h11);  // ADDWF 22,0
        add(11'h11, 14'h02A2, 1, 8'h00, 2'b01, 11'h12);  // SUBWF 22,1
        add(11'h12, 14'h0822, 1, 8'h80, 2'b01, 11'h13);  // MOVF 22,0
        add(11'h13, 14'h0083, 1, 8'h80, 2'b00, 11'h14);  // MOVWF STATUS
        add(11'h14, 14'h3005, 1, 8'h05, 2'b00, 11'h15);  // MOVLW 05
        add(11'h15, 14'h0083, 1, 8'h05, 2'b11, 11'h16);  // MOVWF STATUS
        add(11'h16, 14'h0803, 1, 8'h05, 2'b01, 11'h17);  // MOVF STATUS,0
        add(11'h17, 14'h0100, 1, 8'h00, 2'b11, 11'h18);  // CLRW
        add(11'h18, 14'h01A1, 1, 8'h00, 2'b11, 11'h19);  // CLRF 21
        add(11'h19, 14'h17A1, 1, 8'h00, 2'b11, 11'h1A);  // BSF 21,7
        add(11'h1A, 14'h1003, 1, 8'h00, 2'b10, 11'h1B);  // BCF STATUS,0
        add(11'h1B, 14'h0821, 1, 8'h80, 2'b00, 11'h1C);  // MOVF 21,0
        add(11'h1C, 14'h0621, 1, 8'h00, 2'b10, 11'h1D);  // XORWF 21,0
        add(11'h1D, 14'h0000, 1, 8'h00, 2'b10, 11'h1E);  // NOP
        add(11'h1E, 14'h2840, 1, 8'h00, 2'b10, 11'h40);  // GOTO 40
        add(11'h40, 14'h3001, 1, 8'h01, 2'b10, 11'h41);  // MOVLW 01
        add(11'h41, 14'h00A0, 1, 8'h01, 2'b10, 11'h42);  // MOVWF 20
        add(11'h42, 14'h0BA0, 1, 8'h01, 2'b10, 11'h44);  // DECFSZ 20,1 skips
        add(11'h43, 14'h30EE, 0, 8'h00, 2'b00, 11'h00);  // skipped
        add(11'h44, 14'h0820, 1, 8'h00, 2'b10, 11'h45);  // MOVF 20,0
        add(11'h45, 14'h1D03, 1, 8'h00, 2'b10, 11'h47);  // BTFSS STATUS,2 skips
        add(11'h46, 14'h30EE, 0, 8'h00, 2'b00, 11'h00);  // skipped
        add(11'h47, 14'h1903, 1, 8'h00, 2'b10, 11'h48);  // BTFSC STATUS,2
        add(11'h48, 14'h0F20, 1, 8'h01, 2'b10, 11'h49);  // INCFSZ 20,0
        add(11'h49, 14'h39F0, 1, 8'h00, 2'b10, 11'h4A);  // ANDLW F0

        clear_roms();
        for (int k = 0; k < vecs.size(); k++) rom8[vecs[k].addr] = vecs[k].instr;
        do_reset();
        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].retire) begin
                wait_retire(1'b0, $sformatf("vec%0d", k));
                chk($sformatf("vec%0d w_q", k), 32'(w8), 32'(vecs[k].ew));
                chk($sformatf("vec%0d status_q", k), 32'(st8), 32'(vecs[k].est));
                chk($sformatf("vec%0d pc_q", k), 32'(pc8), 32'(vecs[k].epc));
            end
        end

        // CALL then RETLW
        clear_roms();
        rom8[4]     = 14'h2010;   // CALL 0x010
        rom8[5]     = 14'h2805;   // GOTO 5
        rom8[11'h10] = 14'h343C;  // RETLW 0x3C
        do_reset();
        repeat (4) wait_retire(1'b0, "t3 nop");
        wait_retire(1'b0, "t3 call");
        chk("t3 call pc_q", 32'(pc8), 32'h10);
        wait_retire(1'b0, "t3 retlw");
        chk("t3 retlw pc_q", 32'(pc8), 32'h5);
        chk("t3 retlw w_q", 32'(w8), 32'h3C);
        chk("t3 stk flags", 32'({ovf8, unf8}), 32'h0);

        // Nine nested CALLs into an 8-deep stack, then nine RETURNs
        clear_roms();
        for (int i = 0; i < 9; i++) begin
            rom8[2*i]   = 14'h2000 | 14'(2*i + 2);   // CALL 2i+2
            rom8[2*i+1] = 14'h0008;                  // RETURN
        end
        rom8[18] = 14'h0008;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wait_retire(1'b0, "t4 call");
            chk($sformatf("t4 call%0d pc_q", i), 32'(pc8), 32'(2*i + 2));
            if (i == 7) chk("t4 no ovf at 8", 32'(ovf8), 32'h0);
        end
        chk("t4 ovf after 9th", 32'(ovf8), 32'h1);
        for (int j = 0; j < 8; j++) begin
            wait_retire(1'b0, "t4 ret");
            chk($sformatf("t4 ret%0d pc_q", j), 32'(pc8), 32'(17 - 2*j));
        end
        chk("t4 no unf after 8", 32'(unf8), 32'h0);
        wait_retire(1'b0, "t4 ret9");
        chk("t4 unf pc_q", 32'(pc8), 32'h0);
        chk("t4 unf flag", 32'(unf8), 32'h1);
        chk("t4 ovf sticky", 32'(ovf8), 32'h1);

        // 16-bit datapath and skip wrap past the last ROM address
        clear_roms();
        rom16[0]      = 14'h30FF;  // MOVLW 0xFF
        rom16[1]      = 14'h3E01;  // ADDLW 0x01
        rom16[2]      = 14'h2FFE;  // GOTO 0x7FE
        rom16[11'h7FE] = 14'h1903; // BTFSC STATUS,2 (Z=0 -> skip)
        do_reset();
        repeat (2) wait_retire(1'b1, "t6 alu");
        chk("t6 w_q 16-bit", 32'(w16), 32'h0100);
        chk("t6 status_q 16-bit", 32'(st16), 32'h0);
        wait_retire(1'b1, "t6 goto");
        chk("t6 goto pc_q", 32'(pc16), 32'h7FE);
        wait_retire(1'b1, "t6 skip");
        chk("t6 skip wrap pc_q", 32'(pc16), 32'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
